regfile_write_arbiter: RTL and testbench
========================================

# regfile_write_arbiter

Arbitrates the three register-file write requesters (ALU writeback, multiplier writeback, load writeback) onto one register-file write port using a four-phase req/ack handshake per requester. Round-robin grant, one write in flight at a time. Sits between the execute/memory stages and the register file; its write-port outputs feed the register file's `write_address_1`/`write_data_1`/`write_enable_1` inputs. Replaces the per-port free-running writes with sequenced, acknowledged writes.

## Interface
Parameters:
- `N`, 32, register data width
- `AW`, 4, register address width (16 registers)
- `NUM_REQ`, 3, number of write requesters (fixed at 3 in this revision)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  clock
  - `rst_n`  in  1  reset
- Requester side:
  - `req`  in  NUM_REQ  per-requester write request
  - `req_addr`  in  NUM_REQ*AW  packed destination addresses; requester i is bits [i*AW +: AW]
  - `req_data`  in  NUM_REQ*N  packed write data; requester i is bits [i*N +: N]
  - `ack`  out  NUM_REQ  per-requester acknowledge (one-hot or zero)
- Register-file side:
  - `wr_en`  out  1  register-file write enable
  - `wr_addr`  out  AW  register-file write address
  - `wr_data`  out  N  register-file write data
- Status:
  - `busy`  out  1  high in every state except IDLE
  - `grant_id`  out  2  index of the current or last granted requester

## Operation
- FSM states and transitions:
  - IDLE: if any `req` is high, pick the winner, latch its addr/data, go to WRITE.
  - WRITE: `wr_en`=1 for exactly one cycle, then go to ACK.
  - ACK: `ack[g]`=1; stay in ACK while `req[g]`=1; when `req[g]`=0, drop `ack[g]`, advance the pointer, go to IDLE.
- Round-robin winner selection:
  - Search starts at pointer `ptr` and wraps 2→0.
  - On release of grant g, `ptr` = g+1 (mod 3).
  - `ptr` resets to 0.
- Address and data are captured in IDLE on the grant cycle. Changes on `req_addr`/`req_data` after capture have no effect.
- Withdrawn requests: a `req` that drops before it is granted is never written and never acknowledged.
- Other requests raised during WRITE/ACK wait; they are not lost while their `req` stays high.
- `wr_addr`/`wr_data` hold their last values when `wr_en`=0.
- Writes to address 15 (pc) are passed through unchanged. Pc protection is not this block's job.
- Protocol violation: `req[g]` dropped during WRITE. The write still completes, ACK is entered, and the FSM sees `req[g]`=0 and returns to IDLE after one ACK cycle.

## Timing
- All outputs registered. Reset values:
  - `wr_en`=0, `wr_addr`=0, `wr_data`=0
  - `ack`=0, `busy`=0, `grant_id`=0
  - state IDLE, `ptr`=0
- Cycle-level sequence, where `req[i]` is sampled high at edge n while in IDLE:
  - n+1: `wr_en`=1 with the captured addr/data
  - n+2: `ack[i]`=1
- Minimum transaction, with `req` dropped as soon as `ack` is seen: IDLE→WRITE→ACK→ACK→IDLE, i.e. 4 cycles from request sample to the next grant opportunity.
- Handshake rules:
  - Requester holds `req` until it sees `ack`, then drops `req`.
  - `ack` falls one cycle after `req` is sampled low.
  - Requester may re-raise `req` only after `ack` is low.
- Simultaneous requests: exactly one grant per IDLE cycle; there are no simultaneous writes.
- Reset asserted mid-transaction: immediately IDLE, `wr_en`/`ack` low. The in-flight write is lost if it was not yet issued in WRITE.

## Structure
- Package `regfile_arb_pkg`:
  - state enum `arb_state_t` {IDLE, WRITE, ACK}
  - `NUM_REQ` constant
  - `N`/`AW` defaults
- Sub-module `rr_pick`: combinational round-robin priority picker.
  - Inputs: `req[2:0]`, `ptr[1:0]`.
  - Outputs: `valid`, `idx[1:0]`.
- The top level holds the FSM, capture registers and pointer.

## Test plan
- Single request: `req`=3'b001, addr=5, data=32'hDEAD_BEEF → `wr_en`=1 one cycle later with addr 5/data DEADBEEF; `ack`=001 the cycle after; drop `req` → `ack`=0 next cycle, `busy`=0.
- All three requesting from reset (addr 1/2/3) → write order 0,1,2; each `wr_en` pulse exactly one cycle; `grant_id` 0→1→2.
- Fairness: requester 0 re-requests immediately after each release while 1 and 2 are held high → order 0,1,2,0,1,2; no requester skipped.
- Withdrawal: `req[1]` pulsed for one cycle while requester 0 is in ACK → no write to requester 1's addr, `ack[1]` never asserted.
- Data stability: change `req_data[0]` from 32'h1 to 32'h2 during WRITE → `wr_data`=32'h1.
- Reset mid-ACK: assert `rst_n`=0 while `ack`=010 → `ack`=0, `busy`=0, `wr_en`=0 immediately; after release, a fresh `req` of 010 is granted normally with `ptr` starting at 0.

Source files
------------

// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write arbiter.
// The FSM encoding is exported so checkers can bind to the debug state port.
package regfile_arb_pkg;

   localparam int NUM_REQ = 3;
   localparam int DEF_N   = 32;
   localparam int DEF_AW  = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      ACK   = 2'd2
   } arb_state_t;

   // Requester index that follows i in the 0 -> 1 -> 2 -> 0 rotation.
   function automatic logic [1:0] rr_next(input logic [1:0] i);
      return (i >= 2'd2) ? 2'd0 : i + 2'd1;
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request found when
// searching from ptr upwards with wrap 2 -> 0.
module rr_pick
   import regfile_arb_pkg::*;
(
   input  logic [2:0] req,
   input  logic [1:0] ptr,
   output logic       valid,
   output logic [1:0] idx
);

   logic [1:0] cand0;
   logic [1:0] cand1;
   logic [1:0] cand2;

   // An out-of-range pointer is treated as 0 so the search order stays defined.
   assign cand0 = (ptr == 2'd3) ? 2'd0 : ptr;
   assign cand1 = rr_next(cand0);
   assign cand2 = rr_next(cand1);

   always_comb begin
      valid = 1'b0;
      idx   = 2'd0;
      if (req[cand0]) begin
         valid = 1'b1;
         idx   = cand0;
      end else if (req[cand1]) begin
         valid = 1'b1;
         idx   = cand1;
      end else if (req[cand2]) begin
         valid = 1'b1;
         idx   = cand2;
      end
   end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Sequences the ALU, multiplier and load writebacks onto a single
// register-file write port with a four-phase req/ack handshake per requester.
module regfile_write_arbiter
   import regfile_arb_pkg::*;
#(
   parameter int N       = DEF_N,
   parameter int AW      = DEF_AW,
   parameter int NUM_REQ = regfile_arb_pkg::NUM_REQ
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NUM_REQ-1:0]    req,
   input  logic [NUM_REQ*AW-1:0] req_addr,
   input  logic [NUM_REQ*N-1:0]  req_data,
   output logic [NUM_REQ-1:0]    ack,
   output logic                  wr_en,
   output logic [AW-1:0]         wr_addr,
   output logic [N-1:0]          wr_data,
   output logic                  busy,
   output logic [1:0]            grant_id,
   output arb_state_t            dbg_state_o
);

   // Handshake: a requester raises req[i] with addr/data and holds req until
   // ack[i] is seen; it then drops req, ack falls one cycle after req is
   // sampled low, and req may only be raised again once ack is low.

   arb_state_t           state_q, state_d;
   logic [1:0]           ptr_q, ptr_d;
   logic [1:0]           grant_q, grant_d;
   logic [AW-1:0]        addr_q, addr_d;
   logic [N-1:0]         data_q, data_d;
   logic                 wr_en_q, wr_en_d;
   logic [NUM_REQ-1:0]   ack_q, ack_d;

   logic                 pick_valid;
   logic [1:0]           pick_idx;

   rr_pick u_rr_pick (
      .req   (req),
      .ptr   (ptr_q),
      .valid (pick_valid),
      .idx   (pick_idx)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         ptr_q   <= 2'd0;
         grant_q <= 2'd0;
         addr_q  <= '0;
         data_q  <= '0;
         wr_en_q <= 1'b0;
         ack_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         grant_q <= grant_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wr_en_q <= wr_en_d;
         ack_q   <= ack_d;
      end
   end

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      grant_d = grant_q;
      addr_d  = addr_q;
      data_d  = data_q;
      wr_en_d = 1'b0;
      ack_d   = ack_q;
      case (state_q)
         IDLE: begin
            // Address and data are frozen here; later changes on the bus are ignored.
            if (pick_valid) begin
               grant_d = pick_idx;
               addr_d  = req_addr[pick_idx*AW +: AW];
               data_d  = req_data[pick_idx*N +: N];
               wr_en_d = 1'b1;
               state_d = WRITE;
            end
         end
         WRITE: begin
            ack_d   = NUM_REQ'(1) << grant_q;
            state_d = ACK;
         end
         ACK: begin
            if (!req[grant_q]) begin
               ack_d   = '0;
               ptr_d   = rr_next(grant_q);
               state_d = IDLE;
            end
         end
         default: begin
            ack_d   = '0;
            state_d = IDLE;
         end
      endcase
   end

   assign ack         = ack_q;
   assign wr_en       = wr_en_q;
   assign wr_addr     = addr_q;
   assign wr_data     = data_q;
   assign busy        = (state_q != IDLE);
   assign grant_id    = grant_q;
   assign dbg_state_o = state_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios followed by randomized
// requesters, all checked cycle by cycle against a transaction-level model.
module tb_regfile_write_arbiter;
   import regfile_arb_pkg::*;

   localparam int N  = 32;
   localparam int AW = 4;
   localparam int W  = 2 + AW + N;

   // ---------------- clock / reset / DUT ----------------
   logic            clk;
   logic            rst_n;
   logic [2:0]      req;
   logic [3*AW-1:0] req_addr;
   logic [3*N-1:0]  req_data;
   logic [2:0]      ack;
   logic            wr_en;
   logic [AW-1:0]   wr_addr;
   logic [N-1:0]    wr_data;
   logic            busy;
   logic [1:0]      grant_id;
   arb_state_t      dbg_state;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   regfile_write_arbiter #(.N(N), .AW(AW), .NUM_REQ(3)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req         (req),
      .req_addr    (req_addr),
      .req_data    (req_data),
      .ack         (ack),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .busy        (busy),
      .grant_id    (grant_id),
      .dbg_state_o (dbg_state)
   );

   // ---------------- checking helpers ----------------
   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Arbiter seen as transactions: when free, the first raised request in
   // rotation order from m_ptr wins; the write shows one cycle after the
   // grant, the ack from the following cycle until req is seen low.
   logic [W-1:0]  exp_q[$];
   bit            m_busy;
   int            m_cyc;
   int            m_g;
   int            m_ptr;
   logic [AW-1:0] m_addr;
   logic [N-1:0]  m_data;

   initial begin
      m_busy = 0; m_cyc = 0; m_g = 0; m_ptr = 0; m_addr = '0; m_data = '0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_busy = 0; m_cyc = 0; m_g = 0; m_ptr = 0; m_addr = '0; m_data = '0;
            exp_q.delete();
         end else if (!m_busy) begin
            for (int k = 0; k < 3; k++) begin
               int c;
               c = (m_ptr + k) % 3;
               if (!m_busy && req[c]) begin
                  m_busy = 1;
                  m_g    = c;
                  m_cyc  = 1;
                  m_addr = req_addr[c*AW +: AW];
                  m_data = req_data[c*N +: N];
                  exp_q.push_back({2'(c), m_addr, m_data});
               end
            end
         end else if (m_cyc == 1) begin
            m_cyc = 2;
         end else if (!req[m_g]) begin
            m_busy = 0;
            m_ptr  = (m_g + 1) % 3;
         end
      end
   end

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [W-1:0] e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            chk("wr_en", 64'(wr_en), 64'(m_busy && m_cyc == 1));
            if (wr_en) begin
               chk("write_expected", 64'(exp_q.size() != 0), 64'(1));
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  chk("write_id",   64'(grant_id), 64'(e[W-1 -: 2]));
                  chk("write_addr", 64'(wr_addr),  64'(e[N +: AW]));
                  chk("write_data", 64'(wr_data),  64'(e[N-1:0]));
               end
            end
            chk("ack",      64'(ack),      64'((m_busy && m_cyc == 2) ? 3'(1 << m_g) : 3'b000));
            chk("busy",     64'(busy),     64'(m_busy));
            chk("grant_id", 64'(grant_id), 64'(m_g));
            chk("wr_addr_hold", 64'(wr_addr), 64'(m_addr));
            chk("wr_data_hold", 64'(wr_data), 64'(m_data));
         end
      end
   end

   // ---------------- driver ----------------
   // Per-requester behaviour: 0 = quiet, 1 = requesting, 2 = released.
   int r_st[3];
   int r_cnt[3];
   int cfg_raise_pct    = 0;
   int cfg_withdraw_pct = 0;
   int cfg_hold_pct     = 0;
   int cfg_gap          = 0;
   bit cfg_jitter       = 0;

   task automatic raise(input int i, input logic [AW-1:0] a, input logic [N-1:0] d);
      req[i]             = 1'b1;
      req_addr[i*AW +: AW] = a;
      req_data[i*N +: N]   = d;
      r_st[i]            = 1;
   endtask

   task automatic drive_cycle();
      for (int i = 0; i < 3; i++) begin
         case (r_st[i])
            0: begin
               if (r_cnt[i] > 0) r_cnt[i]--;
               else if (int'($urandom_range(99)) < cfg_raise_pct)
                  raise(i, AW'($urandom_range(15)), N'($urandom));
            end
            1: begin
               if (ack[i]) begin
                  if (int'($urandom_range(99)) >= cfg_hold_pct) begin
                     req[i] = 1'b0; r_st[i] = 2; r_cnt[i] = 0;
                  end
               end else if (int'($urandom_range(99)) < cfg_withdraw_pct) begin
                  req[i] = 1'b0; r_st[i] = 2; r_cnt[i] = 3;
               end else if (cfg_jitter && $urandom_range(1) == 1) begin
                  req_data[i*N +: N] = N'($urandom);
               end
            end
            default: begin
               if (r_cnt[i] > 0) r_cnt[i]--;
               else if (!ack[i]) begin
                  r_st[i]  = 0;
                  r_cnt[i] = (cfg_gap > 0) ? int'($urandom_range(cfg_gap)) : 0;
               end
            end
         endcase
      end
   endtask

   task automatic run_cycles(input int n);
      repeat (n) begin
         @(negedge clk);
         drive_cycle();
      end
   endtask

   task automatic wait_quiet();
      bit done;
      done = 0;
      cfg_raise_pct = 0; cfg_withdraw_pct = 0; cfg_hold_pct = 0; cfg_jitter = 0;
      for (int n = 0; n < 200 && !done; n++) begin
         @(negedge clk);
         drive_cycle();
         done = !busy && req == 3'b000 && r_st[0] == 0 && r_st[1] == 0 && r_st[2] == 0;
      end
      chk("quiet_timeout", 64'(done), 64'(1));
   endtask

   task automatic wait_ack(input int i);
      int n;
      n = 0;
      while (!ack[i] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("ack_timeout", 64'(ack[i]), 64'(1));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      rst_n = 1'b0; req = '0; req_addr = '0; req_data = '0;
      for (int i = 0; i < 3; i++) begin r_st[i] = 0; r_cnt[i] = 0; end
      repeat (3) @(negedge clk);
      chk("rst_wr_en",    64'(wr_en),    64'(0));
      chk("rst_wr_addr",  64'(wr_addr),  64'(0));
      chk("rst_wr_data",  64'(wr_data),  64'(0));
      chk("rst_ack",      64'(ack),      64'(0));
      chk("rst_busy",     64'(busy),     64'(0));
      chk("rst_grant_id", 64'(grant_id), 64'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // All three from reset: grants must come out 0, 1, 2.
      raise(0, 4'd1, 32'hA0A0_0001);
      raise(1, 4'd2, 32'hA0A0_0002);
      raise(2, 4'd3, 32'hA0A0_0003);
      run_cycles(20);
      wait_quiet();

      // Single request with the canonical value.
      @(negedge clk);
      raise(0, 4'd5, 32'hDEAD_BEEF);
      run_cycles(8);
      wait_quiet();

      // Data changed during WRITE must not reach the port.
      @(negedge clk);
      raise(0, 4'd3, 32'h1);
      @(negedge clk);
      req_data[0 +: N] = 32'h2;
      run_cycles(8);
      wait_quiet();

      // One-cycle pulse on req[1] while requester 0 sits in ACK.
      @(negedge clk);
      raise(0, 4'd7, 32'h77);
      wait_ack(0);
      req[1] = 1'b1;
      req_addr[AW +: AW] = 4'd9;
      req_data[N +: N] = 32'h99;
      @(negedge clk);
      req[1] = 1'b0;
      run_cycles(8);
      wait_quiet();

      // Fairness: everybody re-requests as soon as allowed.
      cfg_raise_pct = 100; cfg_gap = 0;
      run_cycles(40);
      wait_quiet();

      // Randomized traffic with holds, withdrawals and bus jitter.
      cfg_raise_pct = 30; cfg_withdraw_pct = 5; cfg_hold_pct = 30; cfg_jitter = 1; cfg_gap = 4;
      run_cycles(3000);
      wait_quiet();

      // Reset while requester 1 is being acknowledged.
      @(negedge clk);
      raise(1, 4'hA, 32'h1234);
      wait_ack(1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_ack",   64'(ack),   64'(0));
      chk("midrst_busy",  64'(busy),  64'(0));
      chk("midrst_wr_en", 64'(wr_en), 64'(0));
      req = '0;
      for (int i = 0; i < 3; i++) begin r_st[i] = 0; r_cnt[i] = 0; end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      raise(1, 4'hB, 32'h5678);
      run_cycles(8);
      wait_quiet();

      chk("exp_q_drained", 64'(exp_q.size()), 64'(0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
